// File: rtl/wb_stage_hilo.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_hilo
// Description : Registered write-back stage for one core of the dual-core
//               MIPS pipeline. Captures the MEM/WB pipeline register, selects
//               the register-file write data and owns the architectural
//               HI/LO registers with in-order commit.
//
// Optional feature macro: WB_LOAD_EXT_EN
//   defined   : the read-data path (mem_to_reg = 01) extracts a byte or half
//               lane from the registered read data (little-endian) and sign-
//               or zero-extends it to DATA_W.
//   undefined : read data passes unmodified; load_size_mem, load_unsigned_mem
//               and byte_off_mem are ignored and not registered.
//
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   stall_wb, flush_wb    : hold stage / squash incoming instruction
//   valid_mem             : MEM-stage instruction valid
//   alu_mem, read_data_mem, extended_mem : result sources
//   mem_to_reg_mem        : 01 read data, 10 extended, 00/11 ALU
//   mfhi_mem, mflo_mem    : move-from HI/LO
//   mthi_mem, mtlo_mem    : move-to HI/LO from alu_mem
//   hilo_we_mem, hilo_in_mem : {HI, LO} write from multiply/divide
//   reg_write_mem, write_reg_mem : destination register
//   load_size_mem, load_unsigned_mem, byte_off_mem : load extension control
//   res_wb, write_reg_wb, reg_write_wb, valid_wb : write-back outputs
//   hi_out, lo_out        : architectural HI/LO
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_hilo #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_wb,
    input  logic                  flush_wb,
    input  logic                  valid_mem,
    input  logic [DATA_W-1:0]     alu_mem,
    input  logic [DATA_W-1:0]     read_data_mem,
    input  logic [DATA_W-1:0]     extended_mem,
    input  logic [1:0]            mem_to_reg_mem,
    input  logic                  mfhi_mem,
    input  logic                  mflo_mem,
    input  logic                  mthi_mem,
    input  logic                  mtlo_mem,
    input  logic                  hilo_we_mem,
    input  logic [2*DATA_W-1:0]   hilo_in_mem,
    input  logic                  reg_write_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_mem,
    input  logic [1:0]            load_size_mem,
    input  logic                  load_unsigned_mem,
    input  logic [1:0]            byte_off_mem,
    output logic [DATA_W-1:0]     res_wb,
    output logic [REG_ADDR_W-1:0] write_reg_wb,
    output logic                  reg_write_wb,
    output logic                  valid_wb,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out
);

    // ------------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------------
    logic                  r_valid;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_extended;
    logic [1:0]            r_mem_to_reg;
    logic                  r_mfhi;
    logic                  r_mflo;
    logic                  r_mthi;
    logic                  r_mtlo;
    logic                  r_hilo_we;
    logic [2*DATA_W-1:0]   r_hilo_in;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_reg;

    // Architectural HI/LO
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    logic                  w_load_en;
    logic                  w_commit;
    logic [DATA_W-1:0]     w_load_data;

    // A flush forces a load even while stalled so the bubble replaces the
    // held instruction.
    assign w_load_en = flush_wb | ~stall_wb;

    // The instruction in WB commits on the edge it leaves the stage; a stall
    // keeps it here, so it commits exactly once no matter how long it waits.
    assign w_commit  = r_valid & ~stall_wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_alu        <= '0;
            r_read_data  <= '0;
            r_extended   <= '0;
            r_mem_to_reg <= '0;
            r_mfhi       <= 1'b0;
            r_mflo       <= 1'b0;
            r_mthi       <= 1'b0;
            r_mtlo       <= 1'b0;
            r_hilo_we    <= 1'b0;
            r_hilo_in    <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
        end else if (w_load_en) begin
            r_valid      <= valid_mem & ~flush_wb;
            r_alu        <= alu_mem;
            r_read_data  <= read_data_mem;
            r_extended   <= extended_mem;
            r_mem_to_reg <= mem_to_reg_mem;
            r_mfhi       <= mfhi_mem;
            r_mflo       <= mflo_mem;
            r_mthi       <= mthi_mem;
            r_mtlo       <= mtlo_mem;
            r_hilo_we    <= hilo_we_mem;
            r_hilo_in    <= hilo_in_mem;
            r_reg_write  <= reg_write_mem & ~flush_wb;
            r_write_reg  <= write_reg_mem;
        end
    end

    // ------------------------------------------------------------------------
    // HI/LO commit. A full {HI, LO} write takes precedence over mthi/mtlo.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (r_hilo_we) begin
                r_hi <= r_hilo_in[2*DATA_W-1:DATA_W];
                r_lo <= r_hilo_in[DATA_W-1:0];
            end else begin
                if (r_mthi) begin
                    r_hi <= r_alu;
                end
                if (r_mtlo) begin
                    r_lo <= r_alu;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load lane extraction
    // ------------------------------------------------------------------------
`ifdef WB_LOAD_EXT_EN
    logic [1:0] r_load_size;
    logic       r_load_unsigned;
    logic [1:0] r_byte_off;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_size     <= '0;
            r_load_unsigned <= 1'b0;
            r_byte_off      <= '0;
        end else if (w_load_en) begin
            r_load_size     <= load_size_mem;
            r_load_unsigned <= load_unsigned_mem;
            r_byte_off      <= byte_off_mem;
        end
    end

    // Little-endian lanes: byte at bits [8*off+7 : 8*off], half at off[1].
    assign w_byte = r_read_data[{r_byte_off, 3'b000} +: 8];
    assign w_half = r_read_data[{r_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = r_read_data;
        case (r_load_size)
            2'b01: begin
                if (r_load_unsigned) begin
                    w_load_data = DATA_W'(w_half);
                end else begin
                    w_load_data = DATA_W'($signed(w_half));
                end
            end
            2'b10: begin
                if (r_load_unsigned) begin
                    w_load_data = DATA_W'(w_byte);
                end else begin
                    w_load_data = DATA_W'($signed(w_byte));
                end
            end
            default: w_load_data = r_read_data;
        endcase
    end
`else
    // Extension controls have no effect in this build.
    logic w_unused_load_ctl;
    assign w_unused_load_ctl = ^{load_size_mem, load_unsigned_mem, byte_off_mem};
    assign w_load_data       = r_read_data;
`endif

    // ------------------------------------------------------------------------
    // Result mux. mfhi/mflo read the committed HI/LO with no self-bypass:
    // an instruction's own HI/LO write lands only after it leaves WB.
    // ------------------------------------------------------------------------
    always_comb begin
        res_wb = r_alu;
        if (r_mfhi) begin
            res_wb = r_hi;
        end else if (r_mflo) begin
            res_wb = r_lo;
        end else begin
            case (r_mem_to_reg)
                2'b01:   res_wb = w_load_data;
                2'b10:   res_wb = r_extended;
                default: res_wb = r_alu;
            endcase
        end
    end

    assign write_reg_wb = r_write_reg;
    assign reg_write_wb = r_reg_write & r_valid;
    assign valid_wb     = r_valid;
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_hilo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_hilo
// Description : Self-checking bench for wb_stage_hilo. A vector table covers
//               the result mux, load extraction and in-order HI/LO commit;
//               hand-written sequences cover stall, flush+stall and reset
//               during a stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_hilo;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef WB_LOAD_EXT_EN
    localparam bit LEXT = 1'b1;
`else
    localparam bit LEXT = 1'b0;
`endif

    // flags = {mfhi, mflo, mthi, mtlo, hilo_we}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_MFHI = 5'b10000;
    localparam logic [4:0] F_MFLO = 5'b01000;
    localparam logic [4:0] F_MTHI = 5'b00100;
    localparam logic [4:0] F_MTLO = 5'b00010;
    localparam logic [4:0] F_HWE  = 5'b00001;

    typedef struct {
        logic          valid;
        logic [4:0]    flags;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd;
        logic [DW-1:0] ext;
        logic [1:0]    m2r;
        logic [2*DW-1:0] hin;
        logic          rw;
        logic [AW-1:0] wr;
        logic [1:0]    ls;
        logic          lu;
        logic [1:0]    off;
        logic [DW-1:0] e_res;
        logic          e_valid;
        logic          e_rw;
        logic [DW-1:0] e_hi;
        logic [DW-1:0] e_lo;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall_wb;
    logic            flush_wb;
    logic            valid_mem;
    logic [DW-1:0]   alu_mem;
    logic [DW-1:0]   read_data_mem;
    logic [DW-1:0]   extended_mem;
    logic [1:0]      mem_to_reg_mem;
    logic            mfhi_mem, mflo_mem, mthi_mem, mtlo_mem, hilo_we_mem;
    logic [2*DW-1:0] hilo_in_mem;
    logic            reg_write_mem;
    logic [AW-1:0]   write_reg_mem;
    logic [1:0]      load_size_mem;
    logic            load_unsigned_mem;
    logic [1:0]      byte_off_mem;
    logic [DW-1:0]   res_wb;
    logic [AW-1:0]   write_reg_wb;
    logic            reg_write_wb;
    logic            valid_wb;
    logic [DW-1:0]   hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;

    wb_stage_hilo #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall_wb          (stall_wb),
        .flush_wb          (flush_wb),
        .valid_mem         (valid_mem),
        .alu_mem           (alu_mem),
        .read_data_mem     (read_data_mem),
        .extended_mem      (extended_mem),
        .mem_to_reg_mem    (mem_to_reg_mem),
        .mfhi_mem          (mfhi_mem),
        .mflo_mem          (mflo_mem),
        .mthi_mem          (mthi_mem),
        .mtlo_mem          (mtlo_mem),
        .hilo_we_mem       (hilo_we_mem),
        .hilo_in_mem       (hilo_in_mem),
        .reg_write_mem     (reg_write_mem),
        .write_reg_mem     (write_reg_mem),
        .load_size_mem     (load_size_mem),
        .load_unsigned_mem (load_unsigned_mem),
        .byte_off_mem      (byte_off_mem),
        .res_wb            (res_wb),
        .write_reg_wb      (write_reg_wb),
        .reg_write_wb      (reg_write_wb),
        .valid_wb          (valid_wb),
        .hi_out            (hi_out),
        .lo_out            (lo_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic v, input logic [4:0] f, input logic [DW-1:0] alu,
        input logic [DW-1:0] rd, input logic [DW-1:0] ext, input logic [1:0] m2r,
        input logic [2*DW-1:0] hin, input logic rw, input logic [AW-1:0] wr,
        input logic [1:0] ls, input logic lu, input logic [1:0] off,
        input logic [DW-1:0] e_res, input logic [DW-1:0] e_hi, input logic [DW-1:0] e_lo);
        vec_t t;
        t.valid = v;   t.flags = f;  t.alu = alu; t.rd = rd; t.ext = ext;
        t.m2r = m2r;   t.hin = hin;  t.rw = rw;   t.wr = wr;
        t.ls = ls;     t.lu = lu;    t.off = off;
        t.e_res = e_res; t.e_valid = v; t.e_rw = rw & v;
        t.e_hi = e_hi;   t.e_lo = e_lo;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        valid_mem         = t.valid;
        {mfhi_mem, mflo_mem, mthi_mem, mtlo_mem, hilo_we_mem} = t.flags;
        alu_mem           = t.alu;
        read_data_mem     = t.rd;
        extended_mem      = t.ext;
        mem_to_reg_mem    = t.m2r;
        hilo_in_mem       = t.hin;
        reg_write_mem     = t.rw;
        write_reg_mem     = t.wr;
        load_size_mem     = t.ls;
        load_unsigned_mem = t.lu;
        byte_off_mem      = t.off;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [DW-1:0] e_res,
                           input logic e_valid, input logic e_rw, input logic [AW-1:0] e_wr,
                           input logic [DW-1:0] e_hi, input logic [DW-1:0] e_lo);
        chk({tag, " res_wb"},       64'(res_wb),       64'(e_res));
        chk({tag, " valid_wb"},     64'(valid_wb),     64'(e_valid));
        chk({tag, " reg_write_wb"}, 64'(reg_write_wb), 64'(e_rw));
        chk({tag, " write_reg_wb"}, 64'(write_reg_wb), 64'(e_wr));
        chk({tag, " hi_out"},       64'(hi_out),       64'(e_hi));
        chk({tag, " lo_out"},       64'(lo_out),       64'(e_lo));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];
    vec_t idle;
    vec_t v;

    localparam logic [DW-1:0] RD = 32'h80FF7F01;

    initial begin
        idle = mk(1'b0, F_NONE, '0, '0, '0, 2'b00, '0, 1'b0, '0, 2'b00, 1'b0, 2'b00, '0, '0, '0);

        //           v  flags          alu           rd  ext           m2r   hin                     rw wr  ls     lu off   e_res                           e_hi          e_lo
        tbl[0]  = mk(1, F_HWE,         32'h1234,     0,  0,            2'b00, 64'h00000001_FFFFFFFE, 0, 1,  2'b00, 0, 0,    32'h1234,                       32'h0,        32'h0);
        tbl[1]  = mk(1, F_MFHI,        0,            0,  0,            2'b00, 0,                     1, 3,  2'b00, 0, 0,    32'h00000001,                   32'h1,        32'hFFFFFFFE);
        tbl[2]  = mk(1, F_MFLO,        0,            0,  0,            2'b00, 0,                     1, 4,  2'b00, 0, 0,    32'hFFFFFFFE,                   32'h1,        32'hFFFFFFFE);
        tbl[3]  = mk(1, F_MTHI,        32'h11,       0,  0,            2'b00, 0,                     0, 5,  2'b00, 0, 0,    32'h11,                         32'h1,        32'hFFFFFFFE);
        tbl[4]  = mk(1, F_MTLO,        32'h22,       0,  0,            2'b00, 0,                     0, 6,  2'b00, 0, 0,    32'h22,                         32'h11,       32'hFFFFFFFE);
        tbl[5]  = mk(1, F_MFHI|F_MFLO, 0,            0,  0,            2'b00, 0,                     1, 7,  2'b00, 0, 0,    32'h11,                         32'h11,       32'h22);
        tbl[6]  = mk(1, F_NONE,        32'hCAFE0001, RD, 32'h5555AAAA, 2'b11, 0,                     1, 8,  2'b00, 0, 0,    32'hCAFE0001,                   32'h11,       32'h22);
        tbl[7]  = mk(1, F_NONE,        0,            RD, 32'h5555AAAA, 2'b10, 0,                     1, 9,  2'b00, 0, 0,    32'h5555AAAA,                   32'h11,       32'h22);
        tbl[8]  = mk(1, F_NONE,        0,            RD, 0,            2'b01, 0,                     1, 10, 2'b10, 0, 3,    LEXT ? 32'hFFFFFF80 : RD,       32'h11,       32'h22);
        tbl[9]  = mk(1, F_NONE,        0,            RD, 0,            2'b01, 0,                     1, 11, 2'b01, 1, 2,    LEXT ? 32'h000080FF : RD,       32'h11,       32'h22);
        tbl[10] = mk(1, F_NONE,        0,            RD, 0,            2'b01, 0,                     1, 12, 2'b10, 1, 1,    LEXT ? 32'h0000007F : RD,       32'h11,       32'h22);
        tbl[11] = mk(1, F_NONE,        0,            RD, 0,            2'b01, 0,                     1, 13, 2'b01, 0, 2,    LEXT ? 32'hFFFF80FF : RD,       32'h11,       32'h22);
        tbl[12] = mk(1, F_NONE,        0,            RD, 0,            2'b01, 0,                     1, 14, 2'b00, 0, 1,    RD,                             32'h11,       32'h22);
        tbl[13] = mk(1, F_HWE|F_MTHI,  32'h99,       0,  0,            2'b00, 64'h00000077_00000088, 0, 15, 2'b00, 0, 0,    32'h99,                         32'h11,       32'h22);
        tbl[14] = mk(1, F_MFHI|F_MTHI, 32'h33,       0,  0,            2'b00, 0,                     1, 16, 2'b00, 0, 0,    32'h77,                         32'h77,       32'h88);
        tbl[15] = mk(0, F_MTHI,        32'h44,       0,  0,            2'b00, 0,                     1, 17, 2'b00, 0, 0,    32'h44,                         32'h33,       32'h88);
        tbl[16] = idle;
        tbl[16].e_hi = 32'h33;
        tbl[16].e_lo = 32'h88;

        // Reset then idle
        reset = 1'b1; stall_wb = 1'b0; flush_wb = 1'b0;
        drive(idle);
        step();
        step();
        chk_out("reset", '0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        step();
        chk_out("idle", '0, 1'b0, 1'b0, '0, '0, '0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_res, tbl[i].e_valid, tbl[i].e_rw,
                    tbl[i].wr, tbl[i].e_hi, tbl[i].e_lo);
        end

        // hilo_we held through a 4-cycle stall, then an mthi behind it
        v = mk(1, F_HWE, 32'h1234, 0, 0, 2'b00, 64'hAAAA0001_BBBB0002, 1, 20, 2'b00, 0, 0, '0, '0, '0);
        drive(v);
        step();
        chk_out("stall load", 32'h1234, 1'b1, 1'b1, 5'd20, 32'h33, 32'h88);
        v = mk(1, F_MTHI, 32'hA5, 0, 0, 2'b00, 0, 0, 21, 2'b00, 0, 0, '0, '0, '0);
        drive(v);
        stall_wb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("stall hold%0d", c), 32'h1234, 1'b1, 1'b1, 5'd20, 32'h33, 32'h88);
        end
        stall_wb = 1'b0;
        step();
        chk_out("stall release", 32'hA5, 1'b1, 1'b0, 5'd21, 32'hAAAA0001, 32'hBBBB0002);
        drive(idle);
        step();
        chk_out("mthi after hwe", '0, 1'b0, 1'b0, '0, 32'hA5, 32'hBBBB0002);
        step();
        chk_out("hilo settled", '0, 1'b0, 1'b0, '0, 32'hA5, 32'hBBBB0002);

        // flush together with stall: bubble replaces the held mthi uncommitted
        v = mk(1, F_MTHI, 32'h5A, 0, 0, 2'b00, 0, 1, 9, 2'b00, 0, 0, '0, '0, '0);
        drive(v);
        step();
        chk_out("flush pre", 32'h5A, 1'b1, 1'b1, 5'd9, 32'hA5, 32'hBBBB0002);
        v = mk(1, F_MTHI, 32'h66, 0, 0, 2'b00, 0, 1, 10, 2'b00, 0, 0, '0, '0, '0);
        drive(v);
        stall_wb = 1'b1; flush_wb = 1'b1;
        step();
        chk_out("flush+stall", 32'h66, 1'b0, 1'b0, 5'd10, 32'hA5, 32'hBBBB0002);
        stall_wb = 1'b0; flush_wb = 1'b0;
        drive(idle);
        step();
        chk_out("flush after", '0, 1'b0, 1'b0, '0, 32'hA5, 32'hBBBB0002);

        // reset while an mthi is stalled: discarded, no commit on the reset edge
        v = mk(1, F_MTHI, 32'h77, 0, 0, 2'b00, 0, 1, 11, 2'b00, 0, 0, '0, '0, '0);
        drive(v);
        step();
        drive(idle);
        stall_wb = 1'b1;
        step();
        chk_out("rst stall hold", 32'h77, 1'b1, 1'b1, 5'd11, 32'hA5, 32'hBBBB0002);
        reset = 1'b1;
        step();
        chk_out("rst mid-stall", '0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0; stall_wb = 1'b0;
        step();
        chk_out("rst post", '0, 1'b0, 1'b0, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage_hilo.md
# wb_stage_hilo

Parametrised, registered write-back stage for the dual-core MIPS pipeline: it captures the MEM/WB pipeline register, selects the register-file write data, and owns the architectural HI/LO registers.
- Adds stall/flush control, a valid bit, in-order HI/LO commit (multiply/divide results, `mthi`/`mtlo`), and optional load byte/half extraction.
- One instance per core, between the memory stage and the register file / forwarding network.

## Interface
Parameters:
- `DATA_W`, 32, datapath width (must be a multiple of 8, ≥16)
- `REG_ADDR_W`, 5, register-file address width

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `stall_wb` in 1: hold stage contents, suppress HI/LO commit
- `flush_wb` in 1: squash instruction entering WB (priority over stall)
- `valid_mem` in 1: MEM-stage instruction valid
- `alu_mem`, `read_data_mem`, `extended_mem` in `DATA_W`: result sources
- `mem_to_reg_mem` in 2: 01 read data, 10 extended, 00/11 ALU
- `mfhi_mem`, `mflo_mem` in 1: move-from HI/LO
- `mthi_mem`, `mtlo_mem` in 1: write HI/LO from `alu_mem`
- `hilo_we_mem` in 1: write HI/LO from `hilo_in_mem`
- `hilo_in_mem` in `2*DATA_W`: {HI, LO} product/quotient-remainder
- `reg_write_mem` in 1, `write_reg_mem` in `REG_ADDR_W`: destination
- `load_size_mem` in 2: 00 word, 01 half, 10 byte, 11 word
- `load_unsigned_mem` in 1, `byte_off_mem` in 2: load extension control
- `res_wb` out `DATA_W`: register-file write data
- `write_reg_wb` out `REG_ADDR_W`, `reg_write_wb` out 1, `valid_wb` out 1
- `hi_out`, `lo_out` out `DATA_W`: architectural HI/LO

## Operation
- Stage register loads all `*_mem` inputs on each edge unless `stall_wb`.
- If `flush_wb` is asserted at the load edge, the stage loads `valid`=0 and `reg_write`=0. `flush_wb` wins over `stall_wb`.
- `reg_write_wb` = registered `reg_write` AND `valid_wb`.
- Result mux (combinational from stage register):
  - `mfhi` → `hi_out`.
  - else `mflo` → `lo_out`.
  - else `mem_to_reg` select. Both `mfhi` and `mflo` set: `mfhi` wins.
- Commit: when `valid_wb` and not `stall_wb`, at the edge:
  - `hilo_we` writes HI and LO from `hilo_in`. It wins over `mthi`/`mtlo`.
  - Else `mthi` writes HI from registered `alu`; `mtlo` writes LO; both may fire together.
- Each instruction commits HI/LO exactly once, regardless of stall length.
- `mfhi`/`mflo` in WB read HI/LO as committed by all older instructions. There is no self-bypass: an instruction that both writes and reads HI sees the old value.
- Stall holds `res_wb` and `reg_write_wb` asserted. A repeated register-file write of the same value is permitted.

## Timing
- Latency: one cycle from MEM inputs to `res_wb`/`valid_wb`. HI/LO update becomes visible on `hi_out`/`lo_out` the cycle after commit.
- Reset: all stage-register fields 0, `HI`=`LO`=0. Consequently `res_wb`=0, `write_reg_wb`=0, `reg_write_wb`=0, `valid_wb`=0, `hi_out`=`lo_out`=0.
- Reset mid-stall discards the held instruction; no HI/LO commit occurs on the reset edge.
- Simultaneous `flush_wb` and `stall_wb`: bubble loaded; the previous WB instruction still commits if `valid_wb` and not stalled (it is stalled here, so no commit).
- Back-to-back `mthi` then `mfhi`: the second sees the first's value (commit edge precedes its WB cycle).

## Configuration
- `WB_LOAD_EXT_EN` defined: the read-data path (`mem_to_reg`=01) extracts a lane from registered `read_data` by `byte_off`, little-endian.
  - Byte: bits [8·off+7 : 8·off].
  - Half: lane `off[1]`.
  - Word: unchanged.
  - Sign-extended, or zero-extended when `load_unsigned`, to `DATA_W`.
- Undefined: `read_data` passes unmodified; `load_size`, `load_unsigned`, and `byte_off` are ignored and not registered.

## Test plan
- Reset then idle → all outputs 0; `hi_out`=`lo_out`=0.
- `hilo_we`=1, `hilo_in`=0x00000001_FFFFFFFE; next instruction `mfhi`, then `mflo` → `res_wb`=0x00000001, then 0xFFFFFFFE.
- `hilo_we` held 4 cycles with `stall_wb`, then released → HI/LO written once; a concurrent `mthi` on the following instruction with `alu`=0xA5 → HI=0xA5, LO unchanged.
- `flush_wb` with `stall_wb` and `reg_write_mem`=1 → `valid_wb`=0, `reg_write_wb`=0, HI/LO unchanged.
- `WB_LOAD_EXT_EN`: `read_data`=0x80FF7F01.
  - Byte, off=3, signed → 0xFFFFFF80.
  - Half, off=2, unsigned → 0x000080FF.
  - Without the macro → 0x80FF7F01.
- `mfhi`=`mflo`=1 with HI=0x11, LO=0x22 → `res_wb`=0x11; `mem_to_reg`=11 → `alu_mem` value.
